// File: rtl/mem_ctrl_burst.sv
// mem_ctrl_burst: byte-serial memory controller arbitrating lsb loads/stores against icache line bursts
module mem_ctrl_burst #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16,
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush,
  input  logic                    io_buffer_full,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_WIDTH-1:0]   mem_a,
  output logic                    mem_wr,
  input  logic                    lsb_req,
  input  logic                    lsb_we,
  input  logic [2:0]              lsb_funct3,
  input  logic [ADDR_WIDTH-1:0]   lsb_addr,
  input  logic [31:0]             lsb_wdata,
  output logic                    lsb_done,
  output logic [31:0]             lsb_rdata,
  input  logic                    ic_req,
  input  logic [ADDR_WIDTH-1:0]   ic_addr,
  output logic                    ic_done,
  output logic [LINE_BYTES*8-1:0] ic_line,
  output logic [ADDR_WIDTH-1:0]   ic_line_addr,
  output logic                    busy
);
  localparam int OW = $clog2(LINE_BYTES);
  localparam int CW = OW + 1;
  typedef enum logic [2:0] {IDLE, LSB_RD, LSB_WR, IC_RD, IO_WAIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, n_q, n_d, cap_idx;
  logic pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, ic_line_addr_q, ic_line_addr_d;
  logic [2:0] f3_q, f3_d;
  logic [3:0][7:0] wdata_q, wdata_d;
  logic [LINE_BYTES-1:0][7:0] line_q, line_d;
  logic [LINE_BYTES*8-1:0] ic_line_q, ic_line_d;
  logic lsb_done_q, lsb_done_d, ic_done_q, ic_done_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d, w;
  logic lsb_go, ic_go, is_io;
  assign lsb_go = lsb_req && !lsb_done_q;
  assign ic_go = ic_req && !ic_done_q;
  assign is_io = lsb_addr[17:16] == IO_SEL;
  assign cap_idx = cnt_q - 1'b1;
  assign busy = state_q != IDLE;
  assign mem_a = busy ? base_q + ADDR_WIDTH'(cnt_q) : '0;
  assign mem_wr = rdy_in && state_q == LSB_WR;
  assign mem_dout = state_q == LSB_WR ? wdata_q[cnt_q[1:0]] : 8'h00;
  assign lsb_done = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;
  assign ic_done = ic_done_q;
  assign ic_line = ic_line_q;
  assign ic_line_addr = ic_line_addr_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    n_d = n_q;
    pend_d = pend_q;
    base_d = base_q;
    f3_d = f3_q;
    wdata_d = wdata_q;
    line_d = line_q;
    lsb_done_d = 1'b0;
    ic_done_d = 1'b0;
    lsb_rdata_d = lsb_rdata_q;
    ic_line_d = ic_line_q;
    ic_line_addr_d = ic_line_addr_q;
    w = '0;
    if (rdy_in) begin
      unique case (state_q)
        IDLE: begin
          if (!flush && lsb_go) begin
            base_d = lsb_addr;
            f3_d = lsb_funct3;
            wdata_d = lsb_wdata;
            n_d = lsb_funct3[1] ? CW'(4) : lsb_funct3[0] ? CW'(2) : CW'(1);
            cnt_d = '0;
            pend_d = 1'b0;
            state_d = !lsb_we ? LSB_RD : (is_io && io_buffer_full) ? IO_WAIT : LSB_WR;
          end else if (!flush && ic_go) begin
            base_d = ic_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
            n_d = CW'(LINE_BYTES);
            cnt_d = '0;
            pend_d = 1'b0;
            state_d = IC_RD;
          end
        end
        IO_WAIT: state_d = flush ? IDLE : io_buffer_full ? IO_WAIT : LSB_WR;
        LSB_WR: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == n_q - 1'b1) begin
            state_d = IDLE;
            lsb_done_d = 1'b1;
          end
        end
        LSB_RD, IC_RD: begin
          if (pend_q) line_d[cap_idx[OW-1:0]] = mem_din;
          pend_d = cnt_q != n_q;
          cnt_d = cnt_q != n_q ? cnt_q + 1'b1 : cnt_q;
          if (flush) begin
            state_d = IDLE;
          end else if (pend_q && cnt_q == n_q) begin
            state_d = IDLE;
            w = line_d[3:0];
            lsb_done_d = state_q == LSB_RD;
            ic_done_d = state_q == IC_RD;
            lsb_rdata_d = state_q != LSB_RD ? lsb_rdata_q :
                          f3_q == 3'b000 ? {{24{w[7]}}, w[7:0]} :
                          f3_q == 3'b001 ? {{16{w[15]}}, w[15:0]} :
                          f3_q == 3'b100 ? {24'h0, w[7:0]} :
                          f3_q == 3'b101 ? {16'h0, w[15:0]} : w;
            ic_line_d = state_q == IC_RD ? line_d : ic_line_q;
            ic_line_addr_d = state_q == IC_RD ? base_q : ic_line_addr_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (pend_q) begin
      cnt_d = cnt_q - 1'b1;
      pend_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q <= '0;
      n_q <= '0;
      pend_q <= 1'b0;
      base_q <= '0;
      f3_q <= '0;
      wdata_q <= '0;
      line_q <= '0;
      lsb_done_q <= 1'b0;
      ic_done_q <= 1'b0;
      lsb_rdata_q <= '0;
      ic_line_q <= '0;
      ic_line_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      pend_q <= pend_d;
      base_q <= base_d;
      f3_q <= f3_d;
      wdata_q <= wdata_d;
      line_q <= line_d;
      lsb_done_q <= lsb_done_d;
      ic_done_q <= ic_done_d;
      lsb_rdata_q <= lsb_rdata_d;
      ic_line_q <= ic_line_d;
      ic_line_addr_q <= ic_line_addr_d;
    end
  end
endmodule

// File: tb/tb_mem_ctrl_burst.sv
// tb_mem_ctrl_burst: directed bench for mem_ctrl_burst with a byte-wide RAM model
module tb_mem_ctrl_burst;
  localparam int AW = 32;
  localparam int LB = 16;
  logic clk = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, flush = 1'b0, io_buffer_full = 1'b0;
  logic [7:0] mem_din = 8'h00, mem_dout;
  logic [AW-1:0] mem_a;
  logic mem_wr;
  logic lsb_req = 1'b0, lsb_we = 1'b0;
  logic [2:0] lsb_funct3 = 3'b000;
  logic [AW-1:0] lsb_addr = '0;
  logic [31:0] lsb_wdata = '0;
  logic lsb_done;
  logic [31:0] lsb_rdata;
  logic ic_req = 1'b0;
  logic [AW-1:0] ic_addr = '0;
  logic ic_done;
  logic [LB*8-1:0] ic_line;
  logic [AW-1:0] ic_line_addr;
  logic busy;
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [7:0] ram [logic [31:0]];
  mem_ctrl_burst #(.ADDR_WIDTH(AW), .LINE_BYTES(LB), .IO_SEL(2'b11)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_funct3(lsb_funct3), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_line(ic_line),
    .ic_line_addr(ic_line_addr), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    if (mem_wr) ram[mem_a] = mem_dout;
  end
  function automatic logic [7:0] rb(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction
  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic lsb_op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input int frz_at, output logic [31:0] rd, output int lat);
    int t0 = -1;
    logic ok = 1'b0;
    rd = 'x;
    lat = -1;
    @(negedge clk);
    lsb_req = 1'b1; lsb_we = we; lsb_funct3 = f3; lsb_addr = a; lsb_wdata = wd;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (busy && t0 < 0) t0 = cyc;
      if (t0 >= 0 && cyc - t0 == frz_at) rdy_in = 1'b0;
      if (t0 >= 0 && cyc - t0 == frz_at + 3) rdy_in = 1'b1;
      if (lsb_done) begin
        ok = 1'b1; rd = lsb_rdata; lat = cyc - t0; lsb_req = 1'b0;
      end
    end
    lsb_req = 1'b0;
    rdy_in = 1'b1;
    check("lsb_done_seen", ok, 1'b1);
  endtask
  task automatic ic_op(input logic [31:0] a, output int lat);
    int t0 = -1;
    logic ok = 1'b0;
    lat = -1;
    @(negedge clk);
    ic_req = 1'b1; ic_addr = a;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (busy && t0 < 0) t0 = cyc;
      if (ic_done) begin
        ok = 1'b1; lat = cyc - t0; ic_req = 1'b0;
      end
    end
    ic_req = 1'b0;
    check("ic_done_seen", ok, 1'b1);
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    logic [31:0] rd;
    logic [LB*8-1:0] exp_line;
    logic [31:0] prev_la;
    int lat, ld, is, idn, wrs, t0;
    logic bz, saw;
    ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
    ram[32'h200] = 8'h80; ram[32'h202] = 8'h00; ram[32'h203] = 8'h80;
    for (int k = 0; k < LB; k++) begin
      ram[32'h1230 + k] = 8'(k * 17);
      exp_line[8*k +: 8] = 8'(k * 17);
    end
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_mem_dout", mem_dout, 8'h0);
    check("rst_dones", {lsb_done, ic_done}, 2'b00);
    check("rst_lsb_rdata", lsb_rdata, 32'h0);
    check("rst_ic_line", ic_line, 128'h0);
    check("rst_ic_line_addr", ic_line_addr, 32'h0);
    rst_in = 1'b0;
    lsb_op(1'b0, 3'b010, 32'h100, 0, -10, rd, lat);
    check("lw_data", rd, 32'h12345678);
    check("lw_lat", lat, 5);
    lsb_op(1'b0, 3'b000, 32'h200, 0, -10, rd, lat);
    check("lb_data", rd, 32'hFFFFFF80);
    check("lb_lat", lat, 2);
    lsb_op(1'b0, 3'b100, 32'h200, 0, -10, rd, lat);
    check("lbu_data", rd, 32'h00000080);
    lsb_op(1'b0, 3'b001, 32'h202, 0, -10, rd, lat);
    check("lh_data", rd, 32'hFFFF8000);
    check("lh_lat", lat, 3);
    lsb_op(1'b0, 3'b101, 32'h202, 0, -10, rd, lat);
    check("lhu_data", rd, 32'h00008000);
    ic_op(32'h1234, lat);
    check("ic_lat", lat, 17);
    check("ic_line", ic_line, exp_line);
    check("ic_line_addr", ic_line_addr, 32'h1230);
    lsb_op(1'b1, 3'b010, 32'h400, 32'hA1B2C3D4, -10, rd, lat);
    check("sw_lat", lat, 4);
    check("sw_ram", {rb(32'h403), rb(32'h402), rb(32'h401), rb(32'h400)}, 32'hA1B2C3D4);
    lsb_op(1'b0, 3'b010, 32'h400, 0, -10, rd, lat);
    check("sw_readback", rd, 32'hA1B2C3D4);
    lsb_op(1'b1, 3'b001, 32'h410, 32'hFFFFBEEF, -10, rd, lat);
    check("sh_lat", lat, 2);
    lsb_op(1'b0, 3'b010, 32'h410, 0, -10, rd, lat);
    check("sh_readback", rd, 32'h0000BEEF);
    ld = -1; is = -1; idn = -1; rd = 'x;
    @(negedge clk);
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_funct3 = 3'b010; lsb_addr = 32'h100;
    ic_req = 1'b1; ic_addr = 32'h123F;
    for (int k = 0; k < 200 && idn < 0; k++) begin
      @(negedge clk);
      if (lsb_done) begin ld = cyc; rd = lsb_rdata; lsb_req = 1'b0; end
      if (busy && ld >= 0 && is < 0) is = cyc;
      if (ic_done) begin idn = cyc; ic_req = 1'b0; end
    end
    lsb_req = 1'b0; ic_req = 1'b0;
    check("arb_lsb_data", rd, 32'h12345678);
    check("arb_ic_grant_gap", is - ld, 1);
    check("arb_ic_lat", idn - is, 17);
    check("arb_ic_line_addr", ic_line_addr, 32'h1230);
    @(negedge clk);
    io_buffer_full = 1'b1;
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_funct3 = 3'b000; lsb_addr = 32'h30000; lsb_wdata = 32'h0000005A;
    @(negedge clk);
    wrs = 0; bz = 1'b1;
    repeat (10) begin
      @(negedge clk);
      wrs += int'(mem_wr);
      bz &= busy;
    end
    check("io_wait_no_wr", wrs, 0);
    check("io_wait_busy", bz, 1'b1);
    io_buffer_full = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 50 && !saw; k++) begin
      @(negedge clk);
      wrs += int'(mem_wr);
      if (lsb_done) begin saw = 1'b1; lsb_req = 1'b0; end
    end
    lsb_req = 1'b0;
    check("io_done", saw, 1'b1);
    check("io_wr_count", wrs, 1);
    check("io_ram", rb(32'h30000), 8'h5A);
    prev_la = ic_line_addr;
    @(negedge clk);
    ic_req = 1'b1; ic_addr = 32'h2000;
    for (int k = 0; k < 20 && !busy; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; ic_req = 1'b0;
    check("flush_ic_idle", busy, 1'b0);
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw |= ic_done;
    end
    check("flush_ic_no_done", saw, 1'b0);
    check("flush_ic_line_addr_held", ic_line_addr, prev_la);
    @(negedge clk);
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_funct3 = 3'b010; lsb_addr = 32'h500; lsb_wdata = 32'h11223344;
    t0 = -1; lat = -1;
    for (int k = 0; k < 50 && lat < 0; k++) begin
      @(negedge clk);
      flush = 1'b0;
      if (busy && t0 < 0) begin t0 = cyc; flush = 1'b1; end
      if (lsb_done) begin lat = cyc - t0; lsb_req = 1'b0; end
    end
    flush = 1'b0; lsb_req = 1'b0;
    check("flush_sw_lat", lat, 4);
    check("flush_sw_ram", {rb(32'h503), rb(32'h502), rb(32'h501), rb(32'h500)}, 32'h11223344);
    lsb_op(1'b0, 3'b010, 32'h100, 0, 2, rd, lat);
    check("freeze_lw_data", rd, 32'h12345678);
    lsb_op(1'b1, 3'b010, 32'h600, 32'hCAFEF00D, 1, rd, lat);
    check("freeze_sw_lat", lat, 7);
    check("freeze_sw_ram", {rb(32'h603), rb(32'h602), rb(32'h601), rb(32'h600)}, 32'hCAFEF00D);
    @(negedge clk);
    ic_req = 1'b1; ic_addr = 32'h3000;
    repeat (6) @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    ic_req = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_mem_a", mem_a, 32'h0);
    check("midrst_ic_line_addr", ic_line_addr, 32'h0);
    check("midrst_ic_line", ic_line, 128'h0);
    rst_in = 1'b0;
    lsb_op(1'b0, 3'b010, 32'h100, 0, -10, rd, lat);
    check("post_rst_lw", rd, 32'h12345678);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
